pipe_stage_read: RTL

Registered, handshaked successor of the combinational read/decode stage. It sits between fetch and execute in the core pipeline. Each cycle it decodes one 16-bit instruction into group fields, drives register-file read addresses, and resolves operands with bypass from the execute (EX) and writeback (WB) stages. It stalls on load-use hazards and presents a registered decoded bundle to execute through a valid/ready handshake.

---
 rtl/pipe_stage_read_pkg.sv | 40 ++++
 rtl/instr_field_decode.sv | 47 ++++
 rtl/pipe_stage_read.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipe_stage_read_pkg.sv
// Shared core definitions for the read/decode stage: instruction group codes,
// per-group opcode widths, the source-use mask and the decoded field bundle.
package pipe_stage_read_pkg;

    // Instruction group lives in instruction[15:14].
    localparam logic [1:0] ALU_GROUP  = 2'b00;
    localparam logic [1:0] BRL_GROUP  = 2'b01;
    localparam logic [1:0] MEM_GROUP  = 2'b10;
    localparam logic [1:0] CTRL_GROUP = 2'b11;

    localparam int ALU_LEN  = 7;
    localparam int BRL_LEN  = 7;
    localparam int MEM_LEN  = 5;
    localparam int CTRL_LEN = 4;

    // Which register sources an instruction actually reads: bit0 = s1, bit1 = s2.
    typedef enum logic [1:0] {
        USE_NONE = 2'b00,
        USE_S1   = 2'b01,
        USE_S2   = 2'b10,
        USE_BOTH = 2'b11
    } use_mask_e;

    typedef struct packed {
        logic [1:0]          itype;
        logic [ALU_LEN-1:0]  alu;
        logic [BRL_LEN-1:0]  brl;
        logic [MEM_LEN-1:0]  mem;
        logic [CTRL_LEN-1:0] ctrl;
        logic [5:0]          value;
        logic [7:0]          constant;
        logic [5:0]          offset;
        logic [2:0]          cond;
        logic [2:0]          s1;
        logic [2:0]          s2;
        logic [2:0]          dest;
        use_mask_e           use_mask;
    } dec_fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational group field extraction for one 16-bit instruction, plus the
// mask of register sources the instruction really reads.
module instr_field_decode
    import pipe_stage_read_pkg::*;
(
    input  logic [15:0]  instruction,
    output dec_fields_t  fields
);

    // Pick fields by group; everything a group does not define stays zero.
    always_comb begin
        fields          = '0;
        fields.itype    = instruction[15:14];
        fields.use_mask = USE_BOTH;
        case (instruction[15:14])
            ALU_GROUP: begin
                fields.alu  = instruction[15:9];
                fields.dest = instruction[8:6];
                fields.s1   = instruction[5:3];
                fields.s2   = instruction[2:0];
            end
            BRL_GROUP: begin
                fields.brl      = instruction[15:9];
                fields.dest     = instruction[8:6];
                fields.s2       = instruction[8:6];
                fields.value    = instruction[5:0];
                fields.use_mask = USE_S2;
            end
            MEM_GROUP: begin
                fields.mem      = instruction[15:11];
                fields.dest     = instruction[10:8];
                fields.s2       = instruction[10:8];
                fields.s1       = instruction[2:0];
                fields.constant = instruction[7:0];
            end
            CTRL_GROUP: begin
                fields.ctrl   = instruction[15:12];
                fields.cond   = instruction[11:9];
                fields.s2     = instruction[8:6];
                fields.s1     = instruction[2:0];
                fields.offset = instruction[5:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_stage_read.sv
// Registered read/decode stage between fetch and execute: decodes, reads the
// register file, resolves operands and hands a bundle to execute via
// valid/ready. Build option READ_FORWARDING_EN enables EX/WB bypass; without
// it any pending EX/WB write to a used source stalls the stage instead.
module pipe_stage_read
    import pipe_stage_read_pkg::*;
#(
    parameter int DATA_SIZE     = 32,
    parameter int REG_ADDR_SIZE = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [15:0]                 i_instruction,
    input  logic                        i_flush,
    output logic [REG_ADDR_SIZE-1:0]    o_rf_addr1,
    output logic [REG_ADDR_SIZE-1:0]    o_rf_addr2,
    input  logic [DATA_SIZE-1:0]        i_rf_data1,
    input  logic [DATA_SIZE-1:0]        i_rf_data2,
    input  logic                        i_ex_wr_en,
    input  logic                        i_ex_is_load,
    input  logic [REG_ADDR_SIZE-1:0]    i_ex_wr_addr,
    input  logic [DATA_SIZE-1:0]        i_ex_wr_data,
    input  logic                        i_wb_wr_en,
    input  logic [REG_ADDR_SIZE-1:0]    i_wb_wr_addr,
    input  logic [DATA_SIZE-1:0]        i_wb_wr_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [1:0]                  o_instruction_type,
    output logic [ALU_LEN-1:0]          o_alu_instruction,
    output logic [BRL_LEN-1:0]          o_brl_instruction,
    output logic [MEM_LEN-1:0]          o_mem_instruction,
    output logic [CTRL_LEN-1:0]         o_ctrl_instruction,
    output logic [5:0]                  o_value,
    output logic [7:0]                  o_constant,
    output logic signed [5:0]           o_offset,
    output logic [2:0]                  o_cond,
    output logic [REG_ADDR_SIZE-1:0]    o_source1,
    output logic [REG_ADDR_SIZE-1:0]    o_source2,
    output logic [REG_ADDR_SIZE-1:0]    o_destination,
    output logic signed [DATA_SIZE-1:0] o_operand1,
    output logic signed [DATA_SIZE-1:0] o_operand2,
    output logic [15:0]                 o_instruction
);

    dec_fields_t              dec;
    logic [REG_ADDR_SIZE-1:0] src1, src2, dst;
    logic                     use1, use2;
    logic                     ex_m1, ex_m2, wb_m1, wb_m2;
    logic [DATA_SIZE-1:0]     opnd1, opnd2;
    logic                     hazard;
    logic                     xfer_in;

    instr_field_decode u_decode (
        .instruction (i_instruction),
        .fields      (dec)
    );

    assign src1 = REG_ADDR_SIZE'(dec.s1);
    assign src2 = REG_ADDR_SIZE'(dec.s2);
    assign dst  = REG_ADDR_SIZE'(dec.dest);
    assign use1 = dec.use_mask[0];
    assign use2 = dec.use_mask[1];

    assign o_rf_addr1 = src1;
    assign o_rf_addr2 = src2;

    assign ex_m1 = i_ex_wr_en && (i_ex_wr_addr == src1);
    assign ex_m2 = i_ex_wr_en && (i_ex_wr_addr == src2);
    assign wb_m1 = i_wb_wr_en && (i_wb_wr_addr == src1);
    assign wb_m2 = i_wb_wr_en && (i_wb_wr_addr == src2);

`ifdef READ_FORWARDING_EN
    // EX is younger than WB, so its data wins on a double match.
    assign opnd1  = ex_m1 ? i_ex_wr_data : (wb_m1 ? i_wb_wr_data : i_rf_data1);
    assign opnd2  = ex_m2 ? i_ex_wr_data : (wb_m2 ? i_wb_wr_data : i_rf_data2);
    // Only a load in EX has no data yet; one bubble later it is on the WB bypass.
    assign hazard = i_ex_is_load && ((use1 && ex_m1) || (use2 && ex_m2));
`else
    logic unused_fwd;
    assign unused_fwd = ^{i_ex_wr_data, i_wb_wr_data, i_ex_is_load};
    assign opnd1  = i_rf_data1;
    assign opnd2  = i_rf_data2;
    assign hazard = (use1 && (ex_m1 || wb_m1)) || (use2 && (ex_m2 || wb_m2));
`endif

    // Flush always accepts (and drops) the incoming word.
    assign o_ready = i_flush || ((!o_valid || i_ready) && !hazard);
    assign xfer_in = i_valid && o_ready && !i_flush;

    // Output bundle register: flush > load > drain to bubble > hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid            <= 1'b0;
            o_instruction_type <= '0;
            o_alu_instruction  <= '0;
            o_brl_instruction  <= '0;
            o_mem_instruction  <= '0;
            o_ctrl_instruction <= '0;
            o_value            <= '0;
            o_constant         <= '0;
            o_offset           <= '0;
            o_cond             <= '0;
            o_source1          <= '0;
            o_source2          <= '0;
            o_destination      <= '0;
            o_operand1         <= '0;
            o_operand2         <= '0;
            o_instruction      <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (xfer_in) begin
            o_valid            <= 1'b1;
            o_instruction_type <= dec.itype;
            o_alu_instruction  <= dec.alu;
            o_brl_instruction  <= dec.brl;
            o_mem_instruction  <= dec.mem;
            o_ctrl_instruction <= dec.ctrl;
            o_value            <= dec.value;
            o_constant         <= dec.constant;
            o_offset           <= $signed(dec.offset);
            o_cond             <= dec.cond;
            o_source1          <= src1;
            o_source2          <= src2;
            o_destination      <= dst;
            o_operand1         <= $signed(opnd1);
            o_operand2         <= $signed(opnd2);
            o_instruction      <= i_instruction;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
